// File: rtl/ldpc_3gpp_dec_ibuffer_wctrl.sv
// Write-side sequencer for the double-bank LLR input buffer: data columns, extension parity rows,
// zero-fill of punctured columns / untransmitted rows, then bank close. Option: LDPC_3GPP_DEC_IBUF_WCTRL_LEN_CHECK_EN.
module ldpc_3gpp_dec_ibuffer_wctrl #(
  parameter int pIDX_GR       = 0,
  parameter int pCODE         = 4,
  parameter int pDO_PUNCT     = 0,
  parameter int pD_ADDR_W     = 8,
  parameter int pP_ADDR_W     = 8,
  parameter int pLLR_W        = 5,
  parameter int pROW_BY_CYCLE = 1,
  parameter int pLLR_BY_CYCLE = 8,
  parameter int pTAG_W        = 8,
  localparam int cCOL_BY_CYCLE = (pIDX_GR != 0) ? 14 : 26
) (
  input  logic                                  iclk,
  input  logic                                  ireset,
  input  logic                                  iclkena,
  input  logic                                  istart,
  input  logic [pD_ADDR_W-1:0]                  izwords_m1,
  input  logic [5:0]                            inrows,
  input  logic                                  ipunct,
  input  logic [pTAG_W-1:0]                     itag,
  input  logic                                  ival,
  input  logic                                  ieop,
  input  logic [pLLR_BY_CYCLE-1:0][pLLR_W-1:0]  iLLR,
  input  logic                                  ifulla,
  output logic                                  ordy,
  output logic                                  obusy,
  output logic [cCOL_BY_CYCLE-1:0]              owrite,
  output logic [1:0]                            oclear,
  output logic [pROW_BY_CYCLE-1:0]              opwrite,
  output logic [pROW_BY_CYCLE-1:0]              opclear,
  output logic [pP_ADDR_W-1:0]                  owaddr,
  output logic [pLLR_BY_CYCLE-1:0][pLLR_W-1:0]  oLLR,
  output logic                                  owfull,
  output logic [pTAG_W-1:0]                     owtag,
  output logic                                  oerr
);

  localparam int cDCOL   = cCOL_BY_CYCLE;
  localparam int cC0     = (pDO_PUNCT != 0) ? 2 : 0;
  localparam int cSLOT_W = (pROW_BY_CYCLE > 1) ? $clog2(pROW_BY_CYCLE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLRP = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_CLRR = 3'd4,
    ST_FULL = 3'd5
  } state_t;

  state_t                               state_q, state_d;
  logic [4:0]                           col_q, col_d;
  logic [pD_ADDR_W-1:0]                 word_q, word_d;
  logic [5:0]                           row_q, row_d;
  logic [cSLOT_W-1:0]                   slot_q, slot_d;
  logic [pP_ADDR_W-1:0]                 base_q, base_d;
  logic [pD_ADDR_W-1:0]                 nwm1_q, nwm1_d;
  logic [5:0]                           nrows_q, nrows_d;
  logic [pTAG_W-1:0]                    tag_q, tag_d;

  logic                                 ordy_q, ordy_d;
  logic                                 obusy_q, obusy_d;
  logic [cCOL_BY_CYCLE-1:0]             owrite_q, owrite_d;
  logic [1:0]                           oclear_q, oclear_d;
  logic [pROW_BY_CYCLE-1:0]             opwrite_q, opwrite_d;
  logic [pROW_BY_CYCLE-1:0]             opclear_q, opclear_d;
  logic [pP_ADDR_W-1:0]                 owaddr_q, owaddr_d;
  logic [pLLR_BY_CYCLE-1:0][pLLR_W-1:0] oLLR_q, oLLR_d;
  logic                                 owfull_q, owfull_d;
  logic [pTAG_W-1:0]                    owtag_q, owtag_d;

  logic                                 hs_s;
  logic                                 last_word_s;
  logic                                 last_slot_s;
  logic                                 last_dcol_s;
  logic                                 row_step_s;
  logic [pP_ADDR_W-1:0]                 par_addr_s;
  logic [pROW_BY_CYCLE-1:0]             slot_oh_s;
  logic [5:0]                           nrows_clamp_s;

  assign hs_s        = ival & ordy_q;
  assign last_word_s = (word_q == nwm1_q);
  assign last_slot_s = (slot_q == cSLOT_W'(pROW_BY_CYCLE - 1));
  assign last_dcol_s = (col_q == 5'(cDCOL - 1));
  assign par_addr_s  = base_q + pP_ADDR_W'(word_q);
  assign slot_oh_s   = pROW_BY_CYCLE'(1'b1) << slot_q;

  // Clamp the transmitted row count into the storable range 4..pCODE.
  always_comb begin
    if (inrows < 6'd4) begin
      nrows_clamp_s = 6'd4;
    end else if (inrows > 6'(pCODE)) begin
      nrows_clamp_s = 6'(pCODE);
    end else begin
      nrows_clamp_s = inrows;
    end
  end

  // Next-state, counter and write-command logic.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    word_d     = word_q;
    row_d      = row_q;
    slot_d     = slot_q;
    base_d     = base_q;
    nwm1_d     = nwm1_q;
    nrows_d    = nrows_q;
    tag_d      = tag_q;
    owrite_d   = '0;
    oclear_d   = 2'b00;
    opwrite_d  = '0;
    opclear_d  = '0;
    owaddr_d   = '0;
    oLLR_d     = '0;
    owfull_d   = 1'b0;
    owtag_d    = '0;
    row_step_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (istart && !ifulla) begin
          nwm1_d  = izwords_m1;
          nrows_d = nrows_clamp_s;
          tag_d   = itag;
          word_d  = '0;
          row_d   = 6'd4;
          slot_d  = '0;
          base_d  = '0;
          if (ipunct && (pDO_PUNCT == 0)) begin
            col_d   = 5'd0;
            state_d = ST_CLRP;
          end else begin
            col_d   = 5'(cC0);
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLRP: begin
        owrite_d = cCOL_BY_CYCLE'(1'b1) << col_q;
        oclear_d = 2'b01 << col_q;
        owaddr_d = pP_ADDR_W'(word_q);
        if (last_word_s) begin
          word_d = '0;
          if (col_q == 5'd1) begin
            col_d   = 5'd2;
            state_d = ST_DATA;
          end else begin
            col_d = col_q + 5'd1;
          end
        end else begin
          word_d = word_q + pD_ADDR_W'(1'b1);
        end
      end
      ST_DATA: begin
        if (hs_s) begin
          owrite_d = cCOL_BY_CYCLE'(1'b1) << col_q;
          owaddr_d = pP_ADDR_W'(word_q);
          oLLR_d   = iLLR;
          if (last_word_s) begin
            word_d = '0;
            if (!last_dcol_s) begin
              col_d = col_q + 5'd1;
            end else if (nrows_q > 6'd4) begin
              state_d = ST_PAR;
            end else if (pCODE > 4) begin
              state_d = ST_CLRR;
            end else begin
              state_d = ST_FULL;
            end
          end else begin
            word_d = word_q + pD_ADDR_W'(1'b1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PAR: begin
        if (hs_s) begin
          opwrite_d  = slot_oh_s;
          owaddr_d   = par_addr_s;
          oLLR_d     = iLLR;
          row_step_s = 1'b1;
          if (last_word_s && (row_q == nrows_q - 6'd1)) begin
            state_d = (row_q == 6'(pCODE - 1)) ? ST_FULL : ST_CLRR;
          end else begin
            state_d = ST_PAR;
          end
        end else begin
          state_d = ST_PAR;
        end
      end
      ST_CLRR: begin
        opwrite_d  = slot_oh_s;
        opclear_d  = slot_oh_s;
        owaddr_d   = par_addr_s;
        row_step_s = 1'b1;
        if (last_word_s && (row_q == 6'(pCODE - 1))) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_CLRR;
        end
      end
      ST_FULL: begin
        owfull_d = 1'b1;
        owtag_d  = tag_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Parity row walk: base advances by one row length each time the slot index wraps.
    if (row_step_s) begin
      if (last_word_s) begin
        word_d = '0;
        row_d  = row_q + 6'd1;
        if (last_slot_s) begin
          slot_d = '0;
          base_d = base_q + pP_ADDR_W'(nwm1_q) + pP_ADDR_W'(1'b1);
        end else begin
          slot_d = slot_q + cSLOT_W'(1'b1);
        end
      end else begin
        word_d = word_q + pD_ADDR_W'(1'b1);
      end
    end else begin
      row_d = row_d;
    end
  end

  assign ordy_d  = (state_d == ST_DATA) || (state_d == ST_PAR);
  assign obusy_d = (state_d != ST_IDLE);

`ifdef LDPC_3GPP_DEC_IBUF_WCTRL_LEN_CHECK_EN
  logic oerr_q, oerr_d;
  logic exp_last_s;

  // The last expected word is either the final data word (no extension rows) or the final parity word.
  always_comb begin
    if (state_q == ST_DATA) begin
      exp_last_s = last_dcol_s && last_word_s && (nrows_q == 6'd4);
    end else if (state_q == ST_PAR) begin
      exp_last_s = last_word_s && (row_q == nrows_q - 6'd1);
    end else begin
      exp_last_s = 1'b0;
    end
    oerr_d = hs_s & (ieop != exp_last_s);
  end

  // Error flag register, aligned with the write of the offending word.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      oerr_q <= 1'b0;
    end else if (iclkena) begin
      oerr_q <= oerr_d;
    end
  end

  assign oerr = oerr_q;
`else
  logic unused_eop_s;
  assign unused_eop_s = ieop;
  assign oerr         = 1'b0;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      word_q    <= '0;
      row_q     <= '0;
      slot_q    <= '0;
      base_q    <= '0;
      nwm1_q    <= '0;
      nrows_q   <= '0;
      tag_q     <= '0;
      ordy_q    <= 1'b0;
      obusy_q   <= 1'b0;
      owrite_q  <= '0;
      oclear_q  <= 2'b00;
      opwrite_q <= '0;
      opclear_q <= '0;
      owaddr_q  <= '0;
      oLLR_q    <= '0;
      owfull_q  <= 1'b0;
      owtag_q   <= '0;
    end else if (iclkena) begin
      state_q   <= state_d;
      col_q     <= col_d;
      word_q    <= word_d;
      row_q     <= row_d;
      slot_q    <= slot_d;
      base_q    <= base_d;
      nwm1_q    <= nwm1_d;
      nrows_q   <= nrows_d;
      tag_q     <= tag_d;
      ordy_q    <= ordy_d;
      obusy_q   <= obusy_d;
      owrite_q  <= owrite_d;
      oclear_q  <= oclear_d;
      opwrite_q <= opwrite_d;
      opclear_q <= opclear_d;
      owaddr_q  <= owaddr_d;
      oLLR_q    <= oLLR_d;
      owfull_q  <= owfull_d;
      owtag_q   <= owtag_d;
    end
  end

  assign ordy    = ordy_q;
  assign obusy   = obusy_q;
  assign owrite  = owrite_q;
  assign oclear  = oclear_q;
  assign opwrite = opwrite_q;
  assign opclear = opclear_q;
  assign owaddr  = owaddr_q;
  assign oLLR    = oLLR_q;
  assign owfull  = owfull_q;
  assign owtag   = owtag_q;

endmodule

// File: tb/tb_ldpc_3gpp_dec_ibuffer_wctrl.sv
// Scoreboard bench for ldpc_3gpp_dec_ibuffer_wctrl (BG2, pCODE=8, two parity rows per address, N=4).
module tb_ldpc_3gpp_dec_ibuffer_wctrl;

  logic        iclk = 1'b0;
  logic        ireset, iclkena, istart, ipunct, ival, ieop, ifulla;
  logic [7:0]  izwords_m1, itag;
  logic [5:0]  inrows;
  logic [39:0] iLLR;
  logic        ordy, obusy, owfull, oerr;
  logic [13:0] owrite;
  logic [1:0]  oclear, opwrite, opclear;
  logic [7:0]  owaddr, owtag;
  logic [39:0] oLLR;

  ldpc_3gpp_dec_ibuffer_wctrl #(
    .pIDX_GR(1), .pCODE(8), .pDO_PUNCT(0), .pD_ADDR_W(8), .pP_ADDR_W(8),
    .pLLR_W(5), .pROW_BY_CYCLE(2), .pLLR_BY_CYCLE(8), .pTAG_W(8)
  ) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart),
    .izwords_m1(izwords_m1), .inrows(inrows), .ipunct(ipunct), .itag(itag),
    .ival(ival), .ieop(ieop), .iLLR(iLLR), .ifulla(ifulla),
    .ordy(ordy), .obusy(obusy), .owrite(owrite), .oclear(oclear),
    .opwrite(opwrite), .opclear(opclear), .owaddr(owaddr), .oLLR(oLLR),
    .owfull(owfull), .owtag(owtag), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [13:0] wr;
    logic [1:0]  clr;
    logic [1:0]  pwr;
    logic [1:0]  pclr;
    logic [7:0]  addr;
    logic [39:0] llr;
    logic        full;
    logic [7:0]  tag;
    logic        err;
    logic        chk_addr;
    logic        chk_llr;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  full_cyc = 0;
  int  n_full = 0;

  always @(posedge iclk) cyc <= cyc + 1;

  function automatic logic [39:0] llr_of(input int i);
    logic [39:0] v;
    for (int j = 0; j < 8; j++) v[j*5 +: 5] = 5'((i * 3 + j) & 31);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a write, clear, bank close or error is checked against the queue.
  always @(negedge iclk) begin
    ev_t a, e;
    logic bad;
    if ((owrite != 14'd0) || (oclear != 2'd0) || (opwrite != 2'd0) || (opclear != 2'd0) || owfull || oerr) begin
      a = '0;
      a.wr = owrite; a.clr = oclear; a.pwr = opwrite; a.pclr = opclear;
      a.addr = owaddr; a.llr = oLLR; a.full = owfull; a.tag = owtag; a.err = oerr;
      if (owfull) begin n_full++; full_cyc = cyc; end
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got wr=%h clr=%b pwr=%b pclr=%b addr=%0d full=%b tag=%h err=%b, want nothing",
                 a.wr, a.clr, a.pwr, a.pclr, a.addr, a.full, a.tag, a.err);
      end else begin
        e = sb.pop_front();
        bad = (a.wr !== e.wr) || (a.clr !== e.clr) || (a.pwr !== e.pwr) || (a.pclr !== e.pclr) ||
              (a.full !== e.full) || (a.tag !== e.tag) || (a.err !== e.err) ||
              (e.chk_addr && (a.addr !== e.addr)) || (e.chk_llr && (a.llr !== e.llr));
        if (bad) begin
          n_fail++;
          $display("FAIL sb_write: got wr=%h clr=%b pwr=%b pclr=%b addr=%0d llr=%h full=%b tag=%h err=%b, want wr=%h clr=%b pwr=%b pclr=%b addr=%0d llr=%h full=%b tag=%h err=%b",
                   a.wr, a.clr, a.pwr, a.pclr, a.addr, a.llr, a.full, a.tag, a.err,
                   e.wr, e.clr, e.pwr, e.pclr, e.addr, e.llr, e.full, e.tag, e.err);
        end
      end
    end
  end

  // Expected write sequence of one frame; returns the number of input words it consumes.
  task automatic build_exp(input int nrows, input bit punct, input logic [7:0] tag, input int err_idx, output int nwords);
    ev_t e;
    int k = 0;
    if (punct) begin
      for (int c = 0; c < 2; c++)
        for (int w = 0; w < 4; w++) begin
          e = '0; e.wr = 14'd1 << c; e.clr = 2'd1 << c; e.addr = 8'(w); e.chk_addr = 1'b1;
          sb.push_back(e);
        end
    end
    for (int c = (punct ? 2 : 0); c < 14; c++)
      for (int w = 0; w < 4; w++) begin
        e = '0; e.wr = 14'd1 << c; e.addr = 8'(w); e.llr = llr_of(k); e.err = (k == err_idx);
        e.chk_addr = 1'b1; e.chk_llr = 1'b1;
        sb.push_back(e); k++;
      end
    for (int r = 4; r < 8; r++)
      for (int w = 0; w < 4; w++) begin
        e = '0; e.pwr = 2'd1 << ((r - 4) % 2); e.addr = 8'(((r - 4) / 2) * 4 + w); e.chk_addr = 1'b1;
        if (r < nrows) begin
          e.llr = llr_of(k); e.err = (k == err_idx); e.chk_llr = 1'b1; k++;
        end else begin
          e.pclr = e.pwr;
        end
        sb.push_back(e);
      end
    e = '0; e.full = 1'b1; e.tag = tag;
    sb.push_back(e);
    nwords = k;
  endtask

  task automatic start_frame(input int nrows, input bit punct, input logic [7:0] tag);
    istart = 1'b1; inrows = 6'(nrows); ipunct = punct; itag = tag; izwords_m1 = 8'd3;
    start_cyc = cyc;
    @(posedge iclk); #1;
    istart = 1'b0;
    chk("busy_after_start", 64'(obusy), 64'd1);
  endtask

  task automatic feed(input int nwords, input bit toggle, input int eop_a, input int eop_b, input int stop_at);
    bit acc;
    int budget;
    for (int i = 0; i < nwords; i++) begin
      if (i == stop_at) break;
      if (toggle && (i % 2 == 1)) begin
        ival = 1'b0; @(posedge iclk); #1;
      end
      ival = 1'b1; iLLR = llr_of(i); ieop = (i == eop_a) || (i == eop_b);
      budget = 0;
      do begin
        acc = ordy; @(posedge iclk); #1; budget++;
      end while (!acc && budget < 200);
      if (!acc) begin
        chk("handshake_timeout", 64'(i), 64'(-1));
        break;
      end
    end
    ival = 1'b0; ieop = 1'b0;
  endtask

  task automatic drain();
    for (int b = 0; b < 200 && sb.size() != 0; b++) begin
      @(posedge iclk); #1;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    @(posedge iclk); #1;
    chk("idle_after_frame", {62'd0, obusy, ordy}, 64'd0);
  endtask

  initial begin
    int nw;
    int err_idx;
    int fulls;
    ireset = 1'b1; iclkena = 1'b1; istart = 1'b0; ipunct = 1'b0; ival = 1'b0; ieop = 1'b0;
    ifulla = 1'b0; izwords_m1 = 8'd3; itag = 8'd0; inrows = 6'd8; iLLR = '0;
    repeat (3) @(posedge iclk); #1;
    chk("reset_state", {ordy, obusy, owrite, oclear, opwrite, opclear, owaddr, owfull, owtag, oerr}, 64'd0);
    chk("reset_llr", 64'(oLLR), 64'd0);
    ireset = 1'b0;
    @(posedge iclk); #1;

    // Full frame, back-to-back input, bank close 74 cycles after istart.
    build_exp(8, 1'b0, 8'hA5, -1, nw);
    chk("full_words", 64'(nw), 64'd72);
    start_frame(8, 1'b0, 8'hA5);
    feed(nw, 1'b0, nw - 1, nw - 1, -1);
    drain();
    chk("full_latency", 64'(full_cyc - start_cyc), 64'd74);

    // Punctured columns 0/1 cleared first.
    build_exp(8, 1'b1, 8'h3C, -1, nw);
    chk("punct_words", 64'(nw), 64'd64);
    start_frame(8, 1'b1, 8'h3C);
    chk("punct_no_rdy", 64'(ordy), 64'd0);
    feed(nw, 1'b0, nw - 1, nw - 1, -1);
    drain();

    // Shortened parity: rows 5..7 zero-filled.
    build_exp(5, 1'b0, 8'h51, -1, nw);
    chk("short_words", 64'(nw), 64'd60);
    start_frame(5, 1'b0, 8'h51);
    feed(nw, 1'b0, nw - 1, nw - 1, -1);
    drain();

    // Start refused while all banks are full.
    ifulla = 1'b1; istart = 1'b1; inrows = 6'd8; ipunct = 1'b0; itag = 8'h77;
    @(posedge iclk); #1;
    @(posedge iclk); #1;
    chk("fulla_no_start", 64'(obusy), 64'd0);
    istart = 1'b0; ifulla = 1'b0;
    @(posedge iclk); #1;
    chk("fulla_stay_idle", 64'(obusy), 64'd0);

    // Same frame with 50% input stalls.
    build_exp(8, 1'b0, 8'hC3, -1, nw);
    start_frame(8, 1'b0, 8'hC3);
    feed(nw, 1'b1, nw - 1, nw - 1, -1);
    drain();

    // Reset after 20 words: strobes drop, no bank close.
    build_exp(8, 1'b0, 8'h99, -1, nw);
    start_frame(8, 1'b0, 8'h99);
    feed(nw, 1'b0, nw - 1, nw - 1, 20);
    @(negedge iclk);
    ireset = 1'b1;
    fulls = n_full;
    @(posedge iclk); #1;
    ireset = 1'b0;
    chk("reset_mid_strobes", {owrite, oclear, opwrite, opclear, owfull}, 64'd0);
    chk("reset_mid_idle", {62'd0, obusy, ordy}, 64'd0);
    sb.delete();
    repeat (10) @(posedge iclk); #1;
    chk("reset_mid_no_full", 64'(n_full), 64'(fulls));

    build_exp(8, 1'b0, 8'h42, -1, nw);
    start_frame(8, 1'b0, 8'h42);
    feed(nw, 1'b0, nw - 1, nw - 1, -1);
    drain();

`ifdef LDPC_3GPP_DEC_IBUF_WCTRL_LEN_CHECK_EN
    err_idx = 69;
`else
    err_idx = -1;
`endif
    // Early ieop on word 70 (index 69); the true last word also carries ieop.
    build_exp(8, 1'b0, 8'hE7, err_idx, nw);
    start_frame(8, 1'b0, 8'hE7);
    feed(nw, 1'b0, 69, nw - 1, -1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
